// File: rtl/addr_sel_pkg.sv
// Shared definitions for the address source selector: state encoding and
// parameter helpers used by the selector and its channel mux.
package addr_sel_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_EXCP = 2'd2;

  // Exception vector lives on the highest-numbered channel unless overridden.
  function automatic int default_excp_ch(input int num_src);
    return num_src - 1;
  endfunction

  function automatic int sel_width(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/addr_src_mux.sv
// Combinational channel selector: picks one WIDTH-bit slice of the flattened
// source bus and flags indices that do not name an existing channel.
module addr_src_mux
  import addr_sel_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] data,
  output logic [WIDTH-1:0]         data_sel,
  output logic                     oob
);

  // Out-of-range indices select all-zero data.
  always_comb begin
    data_sel = '0;
    oob      = 1'b1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == k) begin
        data_sel = data[k*WIDTH +: WIDTH];
        oob      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/addr_src_sel.sv
// Address source selector: captures one of NUM_SRC address channels into a
// held register, with an exception path that forces capture of EXCP_CH.
module addr_src_sel
  import addr_sel_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int EXCP_CH = default_excp_ch(NUM_SRC),
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     load,
  input  logic                     addr_release,
  input  logic                     word_access,
  input  logic                     excp_req,
  input  logic                     excp_ack,
  output logic [WIDTH-1:0]         addr_out,
  output logic                     addr_valid,
  output logic                     excp_active,
  output logic                     misaligned,
  output logic                     sel_err,
  output logic [SEL_W-1:0]         sel_latched
);

  localparam logic [SEL_W-1:0] EXCP_IDX = SEL_W'(EXCP_CH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] mux_data;
  logic             mux_oob;
  logic             norm_load;
  logic             capture;

  assign idx       = excp_req ? EXCP_IDX : src_sel;
  assign norm_load = load & ~excp_req & (state != ST_EXCP);
  assign capture   = excp_req | norm_load;

  addr_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC)
  ) u_mux (
    .sel      (idx),
    .data     (src_data),
    .data_sel (mux_data),
    .oob      (mux_oob)
  );

  always_comb begin
    state_nxt = state;
    if (excp_req) begin
      state_nxt = ST_EXCP;
    end else begin
      case (state)
        ST_IDLE: if (load) state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (load)              state_nxt = ST_HOLD;
          else if (addr_release) state_nxt = ST_IDLE;
        end
        ST_EXCP: if (excp_ack) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      addr_out    <= '0;
      sel_latched <= '0;
      misaligned  <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_err <= norm_load & mux_oob;
      if (capture) begin
        addr_out    <= mux_data;
        sel_latched <= idx;
        misaligned  <= word_access & (|mux_data[1:0]);
      end else if (state_nxt == ST_IDLE) begin
        misaligned  <= 1'b0;
      end
    end
  end

  // Status flags decode straight from the state register.
  assign addr_valid  = (state != ST_IDLE);
  assign excp_active = (state == ST_EXCP);

endmodule

// File: tb/tb_addr_src_sel.sv
// Scoreboard bench for addr_src_sel: a 4-channel instance covers the main
// flows, a 3-channel instance covers out-of-range selection.
module tb_addr_src_sel;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   src_sel = '0;
  logic [127:0] src_data;
  logic [95:0]  src_data3;
  logic         load = 1'b0, addr_release = 1'b0, word_access = 1'b0;
  logic         excp_req = 1'b0, excp_ack = 1'b0;

  logic [31:0]  addr_out, addr_out3;
  logic         addr_valid, excp_active, misaligned, sel_err;
  logic         addr_valid3, excp_active3, misaligned3, sel_err3;
  logic [1:0]   sel_latched, sel_latched3;

  always #5 clk = ~clk;

  assign src_data  = {32'h0000_00FD, 32'h0000_2002, 32'h0000_1004, 32'h0000_0100};
  assign src_data3 = {32'h0000_00C4, 32'h0000_00B1, 32'h0000_00A0};

  addr_src_sel #(.WIDTH(32), .NUM_SRC(4)) dut (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data),
    .load(load), .addr_release(addr_release), .word_access(word_access),
    .excp_req(excp_req), .excp_ack(excp_ack),
    .addr_out(addr_out), .addr_valid(addr_valid), .excp_active(excp_active),
    .misaligned(misaligned), .sel_err(sel_err), .sel_latched(sel_latched)
  );

  addr_src_sel #(.WIDTH(32), .NUM_SRC(3)) dut3 (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data3),
    .load(load), .addr_release(addr_release), .word_access(word_access),
    .excp_req(excp_req), .excp_ack(excp_ack),
    .addr_out(addr_out3), .addr_valid(addr_valid3), .excp_active(excp_active3),
    .misaligned(misaligned3), .sel_err(sel_err3), .sel_latched(sel_latched3)
  );

  typedef struct {
    string       name;
    int unsigned due;
    bit          inst;
    logic [37:0] v;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  event        chk_ev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] act(input bit inst);
    if (inst)
      return {addr_out3, addr_valid3, excp_active3, misaligned3, sel_err3, sel_latched3};
    return {addr_out, addr_valid, excp_active, misaligned, sel_err, sel_latched};
  endfunction

  // Monitor: pops every expectation whose cycle has arrived.
  initial begin
    exp_t        e;
    logic [37:0] a;
    forever begin
      @(negedge clk or chk_ev);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        a = act(e.inst);
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL %s: not checked in cycle %0d (now %0d)", e.name, e.due, cyc);
        end else if (a !== e.v) begin
          errors++;
          $display("FAIL %s: got addr=%h v=%b e=%b m=%b err=%b sel=%0d, want addr=%h v=%b e=%b m=%b err=%b sel=%0d",
                   e.name, a[37:6], a[5], a[4], a[3], a[2], a[1:0],
                   e.v[37:6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
        end
      end
    end
  end

  task automatic drive(input bit l, input logic [1:0] s, input bit r, input bit w,
                       input bit eq, input bit ea);
    load = l; src_sel = s; addr_release = r; word_access = w;
    excp_req = eq; excp_ack = ea;
  endtask

  task automatic expect_out(input string nm, input bit inst, input int unsigned due,
                            input logic [31:0] a, input bit v, input bit e,
                            input bit m, input bit er, input logic [1:0] s);
    exp_t x;
    x.name = nm; x.inst = inst; x.due = due;
    x.v = {a, v, e, m, er, s};
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clocked vector: inputs now, outputs checked after the next edge.
  task automatic step(input string nm, input bit inst,
                      input bit l, input logic [1:0] s, input bit r, input bit w,
                      input bit eq, input bit ea,
                      input logic [31:0] a, input bit v, input bit e,
                      input bit m, input bit er, input logic [1:0] es);
    drive(l, s, r, w, eq, ea);
    expect_out(nm, inst, cyc + 1, a, v, e, m, er, es);
    tick();
  endtask

  initial begin
    drive(0, 2'd0, 0, 0, 0, 0);
    tick();
    expect_out("reset", 0, cyc, '0, 0, 0, 0, 0, 2'd0);
    expect_out("reset3", 1, cyc, '0, 0, 0, 0, 0, 2'd0);
    reset = 1'b1;
    tick();

    //        name            i  ld sel  rl w  eq ea  addr          v  e  m  er sel
    step("t1_cap",        0, 1, 2'd1, 0, 0, 0, 0, 32'h0000_1004, 1, 0, 0, 0, 2'd1);
    step("t2_recap",      0, 1, 2'd2, 0, 1, 0, 0, 32'h0000_2002, 1, 0, 1, 0, 2'd2);
    step("t3_hold",       0, 0, 2'd0, 0, 0, 0, 0, 32'h0000_2002, 1, 0, 1, 0, 2'd2);
    step("t4_release",    0, 0, 2'd0, 1, 0, 0, 0, 32'h0000_2002, 0, 0, 0, 0, 2'd2);
    step("t5_cap0",       0, 1, 2'd0, 0, 1, 0, 0, 32'h0000_0100, 1, 0, 0, 0, 2'd0);
    step("t6_excp_prio",  0, 1, 2'd0, 1, 1, 1, 0, 32'h0000_00FD, 1, 1, 1, 0, 2'd3);
    step("t7_excp_ign",   0, 1, 2'd1, 1, 0, 0, 0, 32'h0000_00FD, 1, 1, 1, 0, 2'd3);
    step("t8_ack_req",    0, 0, 2'd0, 0, 1, 1, 1, 32'h0000_00FD, 1, 1, 1, 0, 2'd3);
    step("t9_ack",        0, 0, 2'd0, 0, 0, 0, 1, 32'h0000_00FD, 0, 0, 0, 0, 2'd3);
    step("t10_idle_rel",  0, 0, 2'd0, 1, 0, 0, 0, 32'h0000_00FD, 0, 0, 0, 0, 2'd3);
    step("t11_idle_ldrl", 0, 1, 2'd1, 1, 0, 0, 0, 32'h0000_1004, 1, 0, 0, 0, 2'd1);
    step("t12_load_wins", 0, 1, 2'd2, 1, 1, 0, 0, 32'h0000_2002, 1, 0, 1, 0, 2'd2);
    step("t13_excp_hold", 0, 0, 2'd0, 0, 1, 1, 0, 32'h0000_00FD, 1, 1, 1, 0, 2'd3);

    // Reset asserted between clock edges while in EXCP.
    drive(0, 2'd0, 0, 0, 0, 0);
    #6;
    reset = 1'b0;
    #1;
    expect_out("async_rst", 0, cyc, '0, 0, 0, 0, 0, 2'd0);
    expect_out("async_rst3", 1, cyc, '0, 0, 0, 0, 0, 2'd0);
    -> chk_ev;
    tick();
    reset = 1'b1;

    step("t14_post_rst",  0, 1, 2'd1, 0, 0, 0, 0, 32'h0000_1004, 1, 0, 0, 0, 2'd1);
    step("n3_oob",        1, 1, 2'd3, 0, 1, 0, 0, 32'h0000_0000, 1, 0, 0, 1, 2'd3);
    step("n3_err_pulse",  1, 0, 2'd0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, 0, 2'd3);
    step("n3_excp",       1, 0, 2'd0, 0, 1, 1, 0, 32'h0000_00C4, 1, 1, 0, 0, 2'd2);
    step("n3_excp_noerr", 1, 1, 2'd3, 0, 0, 0, 0, 32'h0000_00C4, 1, 1, 0, 0, 2'd2);
    step("n3_ack",        1, 0, 2'd0, 0, 0, 0, 1, 32'h0000_00C4, 0, 0, 0, 0, 2'd2);
    drive(0, 2'd0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
      checks += sbq.size();
      errors += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
